// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, drives the registered-read ROM, and hands
// instructions to decode over valid/ready with a 2-entry skid FIFO.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
);

  localparam int DATA_W = 32;

  logic [DATA_W-1:0] fetch_pc_p0;
  logic              vld_p1;
  logic [DATA_W-1:0] pc_p1;
  logic [DATA_W-1:0] fifo_inst [2];
  logic [DATA_W-1:0] fifo_pc   [2];
  logic [1:0]        count;

  logic        pop;
  logic        issue;
  logic        push;
  logic        pop_fifo;
  logic [1:0]  occ_after;
  logic [1:0]  count_next;
  logic [1:0]  wr_pos;

  assign rom_addr = fetch_pc_p0;

  always_comb begin
    out_valid = 1'b0;
    out_inst  = '0;
    out_pc    = '0;
    if (count != 2'd0) begin
      out_valid = 1'b1;
      out_inst  = fifo_inst[0];
      out_pc    = fifo_pc[0];
    end else if (vld_p1) begin
      out_valid = 1'b1;
      out_inst  = rom_data;
      out_pc    = pc_p1;
    end
  end

  assign out_pc_plus4 = out_valid ? out_pc + 32'd4 : '0;

  // Occupancy after this cycle's pop must leave room for one more in-flight word.
  always_comb begin
    pop        = out_valid & out_ready;
    occ_after  = count + {1'b0, vld_p1} - {1'b0, pop};
    issue      = (occ_after <= 2'd1) && !redirect_valid;
    push       = vld_p1 && !((count == 2'd0) && pop);
    pop_fifo   = pop && (count != 2'd0);
    count_next = count + {1'b0, push} - {1'b0, pop_fifo};
    wr_pos     = count - {1'b0, pop_fifo};
  end

  // p0 -> p1: PC issue and control state
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_p0 <= RESET_PC;
      vld_p1      <= 1'b0;
      count       <= 2'd0;
    end else if (redirect_valid) begin
      fetch_pc_p0 <= {redirect_pc[31:2], 2'b00};
      vld_p1      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (issue) fetch_pc_p0 <= fetch_pc_p0 + 32'd4;
      vld_p1 <= issue;
      count  <= count_next;
    end
  end

  // p1 -> FIFO: data path, qualified by the control state above
  always_ff @(posedge clock) begin
    if (issue) pc_p1 <= fetch_pc_p0;
    if (pop_fifo) begin
      fifo_inst[0] <= fifo_inst[1];
      fifo_pc[0]   <= fifo_pc[1];
    end
    if (push) begin
      fifo_inst[wr_pos[0]] <= rom_data;
      fifo_pc[wr_pos[0]]   <= pc_p1;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: cycle table plus hand sequences for wrap and reset.
module tb_inst_fetch;

  localparam logic [31:0] KEY = 32'hC0DE_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  int checks = 0;
  int errors = 0;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4)
  );

  always #5 clock = ~clock;

  // Registered-read ROM: word content is a fixed function of its address.
  always @(posedge clock) rom_data <= KEY ^ rom_addr;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        chk;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc,
                     input logic chk, input logic ev, input logic [31:0] epc, input logic [31:0] eaddr);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.chk = chk; v.ev = ev; v.epc = epc; v.eaddr = eaddr;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic run(input int step, input vec_t v);
    logic [31:0] einst, epc, ep4;
    @(negedge clock);
    reset = v.rst; out_ready = v.rdy; redirect_valid = v.rv; redirect_pc = v.rpc;
    #1;
    if (v.chk) begin
      epc   = v.ev ? v.epc : 32'h0;
      einst = v.ev ? (KEY ^ v.epc) : 32'h0;
      ep4   = v.ev ? v.epc + 32'd4 : 32'h0;
      cmp("out_valid", step, {31'b0, out_valid}, {31'b0, v.ev});
      cmp("out_pc", step, out_pc, epc);
      cmp("out_inst", step, out_inst, einst);
      cmp("out_pc_plus4", step, out_pc_plus4, ep4);
      cmp("rom_addr", step, rom_addr, v.eaddr);
    end
  endtask

  initial begin
    //   rst rdy rv  rpc          chk ev  epc          eaddr
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0);
    add(1, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0);   // reset state
    add(0, 1, 0, 32'h0,        1, 0, 32'h0,        32'h0);   // C0 issues 0
    add(0, 1, 0, 32'h0,        1, 1, 32'h0,        32'h4);   // A/0 bypass
    add(0, 0, 0, 32'h0,        1, 1, 32'h4,        32'h8);   // back-pressure x5
    add(0, 0, 0, 32'h0,        1, 1, 32'h4,        32'hC);
    add(0, 0, 0, 32'h0,        1, 1, 32'h4,        32'hC);
    add(0, 0, 0, 32'h0,        1, 1, 32'h4,        32'hC);
    add(0, 0, 0, 32'h0,        1, 1, 32'h4,        32'hC);
    add(0, 1, 0, 32'h0,        1, 1, 32'h4,        32'hC);   // release pops B
    add(0, 1, 0, 32'h0,        1, 1, 32'h8,        32'h10);
    add(0, 1, 0, 32'h0,        1, 1, 32'hC,        32'h14);
    add(0, 1, 0, 32'h0,        1, 1, 32'h10,       32'h18);
    add(0, 1, 1, 32'h43,       1, 1, 32'h14,       32'h1C);  // redirect
    add(0, 1, 0, 32'h0,        1, 0, 32'h0,        32'h40);
    add(0, 1, 0, 32'h0,        1, 1, 32'h40,       32'h44);
    add(0, 1, 0, 32'h0,        1, 1, 32'h44,       32'h48);
    add(0, 0, 0, 32'h0,        1, 1, 32'h48,       32'h4C);  // fill FIFO
    add(0, 0, 0, 32'h0,        1, 1, 32'h48,       32'h50);
    add(0, 0, 1, 32'h80,       1, 1, 32'h48,       32'h50);  // redirect while full
    add(0, 0, 0, 32'h0,        1, 0, 32'h0,        32'h80);
    add(0, 1, 0, 32'h0,        1, 1, 32'h80,       32'h84);
    add(0, 1, 0, 32'h0,        1, 1, 32'h84,       32'h88);

    for (int i = 0; i < vecs.size(); i++) run(i, vecs[i]);

    // Wrap through the top of the address space.
    vecs.delete();
    add(0, 1, 1, 32'hFFFF_FFFD, 1, 1, 32'h88,        32'h8C);
    add(0, 1, 0, 32'h0,         1, 0, 32'h0,         32'hFFFF_FFFC);
    add(0, 1, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 32'h0);
    // Fill the FIFO, then reset (with a competing redirect) mid-stream.
    add(0, 0, 0, 32'h0,         1, 1, 32'h0,         32'h4);
    add(0, 0, 0, 32'h0,         1, 1, 32'h0,         32'h8);
    add(1, 0, 1, 32'h200,       1, 1, 32'h0,         32'h8);
    add(0, 1, 0, 32'h0,         1, 0, 32'h0,         32'h0);
    add(0, 1, 0, 32'h0,         1, 1, 32'h0,         32'h4);
    add(0, 1, 0, 32'h0,         1, 1, 32'h4,         32'h8);
    for (int i = 0; i < vecs.size(); i++) run(100 + i, vecs[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
